// File: rtl/pipe_stage_buf_pkg.sv
// Shared types for the inter-stage pipeline buffer.
package pipe_stage_buf_pkg;

  typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_t;

  localparam int PIPE_DEPTH_MAX = 2;

  function automatic logic [1:0] occ_of(input pipe_state_t s);
    case (s)
      PS_ONE:  occ_of = 2'd1;
      PS_TWO:  occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Parametrised valid/ready pipeline register: single register (DEPTH=1) or
// head+skid pair (DEPTH=2), with synchronous flush and a saturating stall counter.
//
// state    | meaning
// PS_EMPTY | nothing held, out_valid=0
// PS_ONE   | head register valid
// PS_TWO   | head and skid registers valid, upstream blocked
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic push;
  logic pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  if (DEPTH < 1 || DEPTH > PIPE_DEPTH_MAX) begin : g_bad_depth
    $error("pipe_stage_buf: DEPTH must be 1 or 2");
  end
  if (DATA_W < 1 || CNT_W < 1) begin : g_bad_width
    $error("pipe_stage_buf: DATA_W and CNT_W must be >= 1");
  end

  if (DEPTH == 1) begin : g_single
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    assign in_ready  = !reset && !flush && (!valid_q || out_ready);
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign occupancy = {1'b0, valid_q};

    always_ff @(posedge clk) begin
      if (reset || flush) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (push) begin
        valid_q <= 1'b1;
        data_q  <= in_data;
      end else if (pop) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end
    end
  end else begin : g_skid
    pipe_state_t       state_q;
    pipe_state_t       state_d;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] skid_q;

    always_ff @(posedge clk) begin
      if (reset) state_q <= PS_EMPTY;
      else       state_q <= state_d;
    end

    always_comb begin
      state_d = state_q;
      if (flush) begin
        state_d = PS_EMPTY;
      end else begin
        case (state_q)
          PS_EMPTY: if (push) state_d = PS_ONE;
          PS_ONE: begin
            if (push && !pop)      state_d = PS_TWO;
            else if (!push && pop) state_d = PS_EMPTY;
          end
          PS_TWO:   if (pop) state_d = PS_ONE;
          default:  state_d = PS_EMPTY;
        endcase
      end
    end

    // in_ready looks only at the registered state, never at out_ready.
    always_comb begin
      in_ready  = !reset && !flush && (state_q != PS_TWO);
      out_valid = (state_q != PS_EMPTY);
      occupancy = occ_of(state_q);
    end

    always_ff @(posedge clk) begin
      if (reset || flush) begin
        head_q <= '0;
        skid_q <= '0;
      end else begin
        case (state_q)
          PS_EMPTY: if (push) head_q <= in_data;
          PS_ONE: begin
            if (push && pop) head_q <= in_data;
            else if (push)   skid_q <= in_data;
            else if (pop)    head_q <= '0;
          end
          PS_TWO: begin
            if (pop) begin
              head_q <= skid_q;
              skid_q <= '0;
            end
          end
          default: ;
        endcase
      end
    end

    assign out_data = head_q;
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
